spi_slave_mode: RTL and testbench

SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 32 +++
 rtl/spi_slave_mode.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding and legal parameter ranges.
package spi_pkg;

    localparam int unsigned DW_MIN   = 8;
    localparam int unsigned DW_MAX   = 64;
    localparam int unsigned SYNC_MIN = 2;
    localparam int unsigned SYNC_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// taken from the last stage against one further delayed copy.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_c =  sync_q[STAGES-1] & ~dly_q;
    assign fall_c = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave, all four modes, with valid/ready word streams for RX and TX.
// Define SPI_SLAVE_MODE_ERRCNT_EN to add saturating overrun/underrun counters.
module spi_slave_mode
    import spi_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          cs_n,
    output logic          miso,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          overrun,
    output logic          underrun,
    output logic          busy
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
    ,
    output logic [7:0]    ovr_cnt,
    output logic [7:0]    udr_cnt
`endif
);

    localparam int unsigned   CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    if (DW < DW_MIN || DW > DW_MAX) begin : g_dw_check
        $error("spi_slave_mode: DW out of legal range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_sync_check
        $error("spi_slave_mode: SYNC_STAGES out of legal range");
    end

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic cs_s, cs_fall, cs_rise_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .q_o    (sclk_lvl_unused),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_c (mosi_rise_unused),
        .fall_c (mosi_fall_unused)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .q_o    (cs_s),
        .rise_c (cs_rise_unused),
        .fall_c (cs_fall)
    );

    // Leading edge leaves the idle level; CPHA picks which edge samples and which shifts.
    logic lead_c, trail_c, sample_c, shift_c;
    assign lead_c   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_c  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_c = (CPHA == 0) ? lead_c  : trail_c;
    assign shift_c  = (CPHA == 0) ? trail_c : lead_c;

    spi_state_e    state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [DW-1:0] tx_sh_q, rx_sh_q, hold_q, rx_data_q;
    logic          hold_full_q, tx_ready_q, rx_valid_q;
    logic          miso_q, overrun_q, underrun_q, busy_q;

    function automatic logic out_bit(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? w[DW-1] : w[0];
    endfunction

    function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
    endfunction

    logic [DW-1:0] load_word_c, rx_next_c;
    logic          tx_take_c;
    assign load_word_c = hold_full_q ? hold_q : '0;
    assign rx_next_c   = (MSB_FIRST != 0) ? {rx_sh_q[DW-2:0], mosi_s} : {mosi_s, rx_sh_q[DW-1:1]};
    assign tx_take_c   = tx_valid & tx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= ~cs_s;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (tx_take_c) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
                tx_ready_q  <= 1'b0;
            end
            if (cs_s) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                tx_sh_q   <= '0;
                rx_sh_q   <= '0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        state_q    <= SHIFT;
                        underrun_q <= ~hold_full_q;
                        // A capture landing in this same clk stays queued for the next word.
                        if (!tx_take_c) begin
                            hold_full_q <= 1'b0;
                            tx_ready_q  <= 1'b1;
                        end
                        if (CPHA == 0) begin
                            miso_q  <= out_bit(load_word_c);
                            tx_sh_q <= shift_word(load_word_c);
                        end else begin
                            tx_sh_q <= load_word_c;
                        end
                    end
                    SHIFT: begin
                        // In CPHA=0 the shift edge after a word's last sample must not disturb
                        // the first bit of the next word, which LOAD already put on miso.
                        if (shift_c && (CPHA != 0 || bit_cnt_q != '0)) begin
                            miso_q  <= out_bit(tx_sh_q);
                            tx_sh_q <= shift_word(tx_sh_q);
                        end
                        if (sample_c) begin
                            rx_sh_q <= rx_next_c;
                            if (bit_cnt_q == LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= LOAD;
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= rx_next_c;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;

`ifdef SPI_SLAVE_MODE_ERRCNT_EN
    logic [7:0] ovr_cnt_q, udr_cnt_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= 8'd0;
            udr_cnt_q <= 8'd0;
        end else begin
            if (overrun_q && ovr_cnt_q != 8'hFF) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
            if (underrun_q && udr_cnt_q != 8'hFF) begin
                udr_cnt_q <= udr_cnt_q + 8'd1;
            end
        end
    end

    assign ovr_cnt = ovr_cnt_q;
    assign udr_cnt = udr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: one mode-0 32-bit MSB-first slave plus 8-bit LSB-first slaves in modes 1..3.
module tb_spi_slave_mode;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sclk_p [4];
    logic        mosi_p [4];
    logic        cs_p   [4];
    logic        miso_p [4];
    logic [63:0] txd_p  [4];
    logic        txv_p  [4];
    logic        txr_p  [4];
    logic        rxr_p  [4];
    logic        rxv_p  [4];
    logic        busy_p [4];
    logic [31:0] rxd0;
    logic [7:0]  rxd8 [1:3];
    logic        ovr0, udr0;
    logic        ovr_unused [1:3];
    logic        udr_unused [1:3];
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
    logic [7:0]  ovr_cnt0, udr_cnt0;
    logic [7:0]  ovr_cnt_unused [1:3];
    logic [7:0]  udr_cnt_unused [1:3];
`endif

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int ovr_seen = 0;
    int udr_seen = 0;
    logic [31:0] exp_q [$];

    spi_slave_mode #(.DW(32), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk_p[0]),
        .mosi     (mosi_p[0]),
        .cs_n     (cs_p[0]),
        .miso     (miso_p[0]),
        .rx_data  (rxd0),
        .rx_valid (rxv_p[0]),
        .rx_ready (rxr_p[0]),
        .tx_data  (txd_p[0][31:0]),
        .tx_valid (txv_p[0]),
        .tx_ready (txr_p[0]),
        .overrun  (ovr0),
        .underrun (udr0),
        .busy     (busy_p[0])
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
        ,
        .ovr_cnt  (ovr_cnt0),
        .udr_cnt  (udr_cnt0)
`endif
    );

    for (genvar g = 1; g < 4; g++) begin : g_small
        spi_slave_mode #(.DW(8), .CPOL((g >= 2) ? 1 : 0), .CPHA((g != 2) ? 1 : 0),
                         .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .sclk     (sclk_p[g]),
            .mosi     (mosi_p[g]),
            .cs_n     (cs_p[g]),
            .miso     (miso_p[g]),
            .rx_data  (rxd8[g]),
            .rx_valid (rxv_p[g]),
            .rx_ready (rxr_p[g]),
            .tx_data  (txd_p[g][7:0]),
            .tx_valid (txv_p[g]),
            .tx_ready (txr_p[g]),
            .overrun  (ovr_unused[g]),
            .underrun (udr_unused[g]),
            .busy     (busy_p[g])
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
            ,
            .ovr_cnt  (ovr_cnt_unused[g]),
            .udr_cnt  (udr_cnt_unused[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx handshake on the 32-bit slave pops one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ovr0) ovr_seen++;
            if (udr0) udr_seen++;
            if (rxv_p[0] && rxr_p[0]) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL rx_unexpected observed=%0h expected=none", rxd0);
                end else begin
                    check("rx_word", 64'(rxd0), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tx_push(input int d, input logic [63:0] val);
        @(negedge clk);
        txd_p[d] = val;
        txv_p[d] = 1'b1;
        @(negedge clk);
        txv_p[d] = 1'b0;
    endtask

    task automatic half_wait(input int d, input bit push, input logic [63:0] val);
        if (push) begin
            tx_push(d, val);
            repeat (HALF - 2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic xfer(input int d, input int dw, input bit cpol, input bit cpha, input bit msb,
                        input logic [63:0] mo, input int nbits, input bit fill,
                        input logic [63:0] fill_val, output logic [63:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? dw - 1 - i : i;
            if (!cpha) begin
                mosi_p[d] = mo[b];
                half_wait(d, fill && i == 2, fill_val);
                sclk_p[d] = ~cpol;
                mi[b] = miso_p[d];
                half_wait(d, 1'b0, '0);
                sclk_p[d] = cpol;
            end else begin
                sclk_p[d] = ~cpol;
                mosi_p[d] = mo[b];
                half_wait(d, fill && i == 2, fill_val);
                sclk_p[d] = cpol;
                mi[b] = miso_p[d];
                half_wait(d, 1'b0, '0);
            end
        end
    endtask

    task automatic cs_begin(input int d);
        cs_p[d] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_end(input int d);
        repeat (4) @(negedge clk);
        cs_p[d] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [63:0] mi;
        int          hs0;
        logic [7:0]  p_mo [2];
        logic [7:0]  p_tx [2];

        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            sclk_p[d] = (d >= 2) ? 1'b1 : 1'b0;
            mosi_p[d] = 1'b0;
            cs_p[d]   = 1'b1;
            txd_p[d]  = '0;
            txv_p[d]  = 1'b0;
            rxr_p[d]  = (d == 0) ? 1'b1 : 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_miso", 64'(miso_p[0]), 64'd0);
        check("rst_rx_valid", 64'(rxv_p[0]), 64'd0);
        check("rst_rx_data", 64'(rxd0), 64'd0);
        check("rst_tx_ready", 64'(txr_p[0]), 64'd1);
        check("rst_flags", {61'd0, ovr0, udr0, busy_p[0]}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx_ready", 64'(txr_p[0]), 64'd1);
        check("idle_busy", 64'(busy_p[0]), 64'd0);

        // Mode 0 exchange, transmit word preloaded.
        tx_push(0, 64'hDEAD_BEEF);
        check("tx_ready_full", 64'(txr_p[0]), 64'd0);
        exp_q.push_back(32'hA5A5_1234);
        hs0 = hs_count;
        cs_begin(0);
        check("busy_low_cs", 64'(busy_p[0]), 64'd1);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'hA5A5_1234, 32, 1'b1, 64'h55AA_55AA, mi);
        check("m0_miso_word", mi, 64'hDEAD_BEEF);
        cs_end(0);
        check("m0_rx_count", 64'(hs_count - hs0), 64'd1);
        check("m0_no_underrun", 64'(udr_seen), 64'd0);
        check("m0_tx_ready_after", 64'(txr_p[0]), 64'd1);

        // Back-to-back words with rx_ready low: first kept, second dropped.
        rxr_p[0] = 1'b0;
        exp_q.push_back(32'h1111_1111);
        tx_push(0, 64'h0102_0304);
        cs_begin(0);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h1111_1111, 32, 1'b1, 64'h0A0B_0C0D, mi);
        check("ovr_miso_w1", mi, 64'h0102_0304);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h2222_2222, 32, 1'b1, 64'h9999_9999, mi);
        check("ovr_miso_w2", mi, 64'h0A0B_0C0D);
        cs_end(0);
        check("ovr_rx_valid", 64'(rxv_p[0]), 64'd1);
        check("ovr_rx_data", 64'(rxd0), 64'h1111_1111);
        check("ovr_pulses", 64'(ovr_seen), 64'd1);
        rxr_p[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_drained", 64'(rxv_p[0]), 64'd0);

        // No transmit data: zeros on miso, one underrun.
        check("udr_tx_ready", 64'(txr_p[0]), 64'd1);
        exp_q.push_back(32'h1234_5678);
        cs_begin(0);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h1234_5678, 32, 1'b1, 64'h3333_3333, mi);
        check("udr_miso_zero", mi, 64'd0);
        cs_end(0);
        check("udr_pulses", 64'(udr_seen), 64'd1);

        // Partial word aborted by cs_n, then a clean word.
        tx_push(0, 64'hCAFE_F00D);
        hs0 = hs_count;
        cs_begin(0);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF, 13, 1'b0, '0, mi);
        cs_end(0);
        check("part_no_rx", 64'(hs_count - hs0), 64'd0);
        check("part_rx_valid", 64'(rxv_p[0]), 64'd0);
        check("part_miso_zero", 64'(miso_p[0]), 64'd0);
        check("part_tx_ready", 64'(txr_p[0]), 64'd1);
        tx_push(0, 64'h8765_4321);
        exp_q.push_back(32'h0F0F_0F0F);
        cs_begin(0);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h0F0F_0F0F, 32, 1'b1, 64'h4444_4444, mi);
        check("part_next_miso", mi, 64'h8765_4321);
        cs_end(0);
        check("part_next_rx", 64'(hs_count - hs0), 64'd1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
        check("ovr_cnt", 64'(ovr_cnt0), 64'd1);
        check("udr_cnt", 64'(udr_cnt0), 64'd1);
`endif

        // Asynchronous reset in the middle of a word.
        rxr_p[0] = 1'b0;
        tx_push(0, 64'h1357_9BDF);
        cs_begin(0);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h5A5A_5A5A, 32, 1'b1, 64'hFFFF_FFFF, mi);
        check("arst_pre_miso_w", mi, 64'h1357_9BDF);
        xfer(0, 32, 1'b0, 1'b0, 1'b1, 64'h0, 10, 1'b1, 64'h1212_1212, mi);
        check("arst_pre_rx_valid", 64'(rxv_p[0]), 64'd1);
        check("arst_pre_miso", 64'(miso_p[0]), 64'd1);
        check("arst_pre_tx_ready", 64'(txr_p[0]), 64'd0);
        check("arst_pre_busy", 64'(busy_p[0]), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rx_valid", 64'(rxv_p[0]), 64'd0);
        check("arst_rx_data", 64'(rxd0), 64'd0);
        check("arst_miso", 64'(miso_p[0]), 64'd0);
        check("arst_tx_ready", 64'(txr_p[0]), 64'd1);
        check("arst_flags", {61'd0, ovr0, udr0, busy_p[0]}, 64'd0);
`ifdef SPI_SLAVE_MODE_ERRCNT_EN
        check("arst_cnts", {48'd0, ovr_cnt0, udr_cnt0}, 64'd0);
`endif
        cs_p[0]   = 1'b1;
        sclk_p[0] = 1'b0;
        rxr_p[0]  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Modes 1..3, 8-bit LSB-first; the second pair is not bit-reversal symmetric.
        p_mo[0] = 8'h3C; p_tx[0] = 8'hC3;
        p_mo[1] = 8'hA1; p_tx[1] = 8'h5E;
        for (int d = 1; d < 4; d++) begin
            for (int k = 0; k < 2; k++) begin
                tx_push(d, 64'(p_tx[k]));
                check($sformatf("m%0d_tx_ready", d), 64'(txr_p[d]), 64'd0);
                cs_begin(d);
                check($sformatf("m%0d_busy", d), 64'(busy_p[d]), 64'd1);
                xfer(d, 8, (d >= 2), (d != 2), 1'b0, 64'(p_mo[k]), 8, 1'b0, '0, mi);
                cs_end(d);
                check($sformatf("m%0d_miso_%0d", d, k), mi, 64'(p_tx[k]));
                check($sformatf("m%0d_rx_valid_%0d", d, k), 64'(rxv_p[d]), 64'd1);
                check($sformatf("m%0d_rx_data_%0d", d, k), 64'(rxd8[d]), 64'(p_mo[k]));
                @(negedge clk);
                rxr_p[d] = 1'b1;
                @(negedge clk);
                rxr_p[d] = 1'b0;
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
